// File: rtl/ocl_axil_reg_file.sv
// ocl_axil_reg_file: AXI4-Lite slave register file of DEPTH byte-strobed 32-bit words; word 0 [15:0] drives vled_src.
// Define OCL_RF_ACCESS_CNT_EN to add read-only B/R handshake counters at byte addresses DEPTH*4 and DEPTH*4+4.
module ocl_axil_reg_file #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        s_awvalid,
    input  logic [31:0] s_awaddr,
    output logic        s_awready,
    input  logic        s_wvalid,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_wready,
    output logic        s_bvalid,
    output logic [1:0]  s_bresp,
    input  logic        s_bready,
    input  logic        s_arvalid,
    input  logic [31:0] s_araddr,
    output logic        s_arready,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    input  logic        s_rready,
    output logic [15:0] vled_src
);
    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_GOTA = 2'd1, W_GOTD = 2'd2, W_RESP = 2'd3} wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOOK = 2'd1, R_RESP = 2'd2} rd_state_e;

    function automatic logic in_range(input logic [31:0] addr);
        return (addr[31:AW+2] == {(30-AW){1'b0}});
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word, input logic [31:0] new_word,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
            else         res[8*i +: 8] = old_word[8*i +: 8];
        end
        return res;
    endfunction

    logic [1:0]    rst_sync_r;
    logic          rst_n_s;
    wr_state_e     wr_state_r, wr_state_nxt_s;
    rd_state_e     rd_state_r, rd_state_nxt_s;
    logic          awready_s, wready_s, arready_s;
    logic          aw_hs_s, w_hs_s, ar_hs_s;
    logic [31:0]   aw_addr_r, w_data_r, ar_addr_r;
    logic [3:0]    w_strb_r;
    logic          commit_s, commit_ok_s;
    logic [31:0]   commit_addr_s, commit_data_s;
    logic [3:0]    commit_strb_s;
    logic [AW-1:0] commit_idx_s, rd_idx_s;
    logic [31:0]   mem_r [DEPTH];
    logic [31:0]   look_data_s;
    logic [1:0]    look_resp_s;
    logic          bvalid_r, rvalid_r;
    logic [1:0]    bresp_r, rresp_r;
    logic [31:0]   rdata_r;
    logic [15:0]   vled_r;
    logic          unused_s;

    assign unused_s = ^{commit_addr_s[1:0], ar_addr_r[1:0]};

    // Reset asserts asynchronously; its release passes through two flops.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) rst_sync_r <= 2'b00;
        else             rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
    assign rst_n_s = rst_sync_r[1];

    assign aw_hs_s = s_awvalid & awready_s;
    assign w_hs_s  = s_wvalid  & wready_s;
    assign ar_hs_s = s_arvalid & arready_s;

    // Write FSM state register.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) wr_state_r <= W_IDLE;
        else          wr_state_r <= wr_state_nxt_s;
    end

    // Write FSM next state.
    always_comb begin
        wr_state_nxt_s = wr_state_r;
        case (wr_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) wr_state_nxt_s = W_RESP;
                else if (aw_hs_s)      wr_state_nxt_s = W_GOTA;
                else if (w_hs_s)       wr_state_nxt_s = W_GOTD;
                else                   wr_state_nxt_s = W_IDLE;
            end
            W_GOTA: begin
                if (w_hs_s) wr_state_nxt_s = W_RESP;
                else        wr_state_nxt_s = W_GOTA;
            end
            W_GOTD: begin
                if (aw_hs_s) wr_state_nxt_s = W_RESP;
                else         wr_state_nxt_s = W_GOTD;
            end
            W_RESP: begin
                if (s_bready) wr_state_nxt_s = W_IDLE;
                else          wr_state_nxt_s = W_RESP;
            end
            default: wr_state_nxt_s = W_IDLE;
        endcase
    end

    // Write FSM outputs; readies stay low until reset release has been synchronized.
    always_comb begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
        case (wr_state_r)
            W_IDLE:  begin awready_s = rst_n_s; wready_s = rst_n_s; end
            W_GOTA:  begin awready_s = 1'b0;    wready_s = rst_n_s; end
            W_GOTD:  begin awready_s = rst_n_s; wready_s = 1'b0;    end
            W_RESP:  begin awready_s = 1'b0;    wready_s = 1'b0;    end
            default: begin awready_s = 1'b0;    wready_s = 1'b0;    end
        endcase
    end

    // Commit source: live channel or the half of the pair held from an earlier cycle.
    always_comb begin
        commit_s      = 1'b0;
        commit_addr_s = s_awaddr;
        commit_data_s = s_wdata;
        commit_strb_s = s_wstrb;
        case (wr_state_r)
            W_IDLE:  commit_s = aw_hs_s & w_hs_s;
            W_GOTA:  begin commit_s = w_hs_s;  commit_addr_s = aw_addr_r; end
            W_GOTD:  begin commit_s = aw_hs_s; commit_data_s = w_data_r; commit_strb_s = w_strb_r; end
            W_RESP:  commit_s = 1'b0;
            default: commit_s = 1'b0;
        endcase
    end
    assign commit_ok_s  = commit_s & in_range(commit_addr_s);
    assign commit_idx_s = commit_addr_s[AW+1:2];

    // Holding registers for a lone AW or W handshake, plus B channel.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            aw_addr_r <= 32'h0000_0000;
            w_data_r  <= 32'h0000_0000;
            w_strb_r  <= 4'h0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            if (aw_hs_s) aw_addr_r <= s_awaddr;
            if (w_hs_s) begin
                w_data_r <= s_wdata;
                w_strb_r <= s_wstrb;
            end
            bvalid_r <= (wr_state_nxt_s == W_RESP);
            if (commit_s) bresp_r <= commit_ok_s ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Byte-strobed array write port.
    always_ff @(posedge clk_main_a0) begin
        if (commit_ok_s) begin
            for (int i = 0; i < 4; i++) begin
                if (commit_strb_s[i]) mem_r[commit_idx_s][8*i +: 8] <= commit_data_s[8*i +: 8];
            end
        end
    end

    // Shadow of word 0 bytes 0/1.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            vled_r <= 16'h0000;
        end else if (commit_ok_s && (commit_idx_s == {AW{1'b0}})) begin
            if (commit_strb_s[0]) vled_r[7:0]  <= commit_data_s[7:0];
            if (commit_strb_s[1]) vled_r[15:8] <= commit_data_s[15:8];
        end
    end

`ifdef OCL_RF_ACCESS_CNT_EN
    localparam logic [29:0] WR_CNT_WORD = 30'(DEPTH);
    localparam logic [29:0] RD_CNT_WORD = 30'(DEPTH + 1);
    logic [31:0] wr_cnt_r, rd_cnt_r;

    // Saturating B/R handshake counters.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            wr_cnt_r <= 32'h0000_0000;
            rd_cnt_r <= 32'h0000_0000;
        end else begin
            if (bvalid_r && s_bready && (wr_cnt_r != 32'hFFFF_FFFF)) wr_cnt_r <= wr_cnt_r + 32'd1;
            if (rvalid_r && s_rready && (rd_cnt_r != 32'hFFFF_FFFF)) rd_cnt_r <= rd_cnt_r + 32'd1;
        end
    end
`endif

    // Read FSM state register.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) rd_state_r <= R_IDLE;
        else          rd_state_r <= rd_state_nxt_s;
    end

    // Read FSM next state.
    always_comb begin
        rd_state_nxt_s = rd_state_r;
        case (rd_state_r)
            R_IDLE: begin
                if (ar_hs_s) rd_state_nxt_s = R_LOOK;
                else         rd_state_nxt_s = R_IDLE;
            end
            R_LOOK: rd_state_nxt_s = R_RESP;
            R_RESP: begin
                if (s_rready) rd_state_nxt_s = R_IDLE;
                else          rd_state_nxt_s = R_RESP;
            end
            default: rd_state_nxt_s = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        arready_s = 1'b0;
        case (rd_state_r)
            R_IDLE:  arready_s = rst_n_s;
            R_LOOK:  arready_s = 1'b0;
            R_RESP:  arready_s = 1'b0;
            default: arready_s = 1'b0;
        endcase
    end

    // Lookup data; a same-cycle commit to the same word is merged in (write-first).
    assign rd_idx_s = ar_addr_r[AW+1:2];
    always_comb begin
        look_data_s = ERR_RDATA;
        look_resp_s = RESP_SLVERR;
        if (in_range(ar_addr_r)) begin
            look_resp_s = RESP_OKAY;
            if (commit_ok_s && (commit_idx_s == rd_idx_s))
                look_data_s = byte_merge(mem_r[rd_idx_s], commit_data_s, commit_strb_s);
            else
                look_data_s = mem_r[rd_idx_s];
        end
`ifdef OCL_RF_ACCESS_CNT_EN
        else if (ar_addr_r[31:2] == WR_CNT_WORD) begin
            look_data_s = wr_cnt_r;
            look_resp_s = RESP_OKAY;
        end else if (ar_addr_r[31:2] == RD_CNT_WORD) begin
            look_data_s = rd_cnt_r;
            look_resp_s = RESP_OKAY;
        end
`endif
        else begin
            look_data_s = ERR_RDATA;
            look_resp_s = RESP_SLVERR;
        end
    end

    // AR latch and R channel registers.
    always_ff @(posedge clk_main_a0 or negedge rst_n_s) begin
        if (!rst_n_s) begin
            ar_addr_r <= 32'h0000_0000;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= RESP_OKAY;
        end else begin
            if (ar_hs_s) ar_addr_r <= s_araddr;
            rvalid_r <= (rd_state_nxt_s == R_RESP);
            if (rd_state_r == R_LOOK) begin
                rdata_r <= look_data_s;
                rresp_r <= look_resp_s;
            end
        end
    end

    assign s_awready = awready_s;
    assign s_wready  = wready_s;
    assign s_arready = arready_s;
    assign s_bvalid  = bvalid_r;
    assign s_bresp   = bresp_r;
    assign s_rvalid  = rvalid_r;
    assign s_rdata   = rdata_r;
    assign s_rresp   = rresp_r;
    assign vled_src  = vled_r;
endmodule

// File: tb/tb_ocl_axil_reg_file.sv
// Self-checking bench for ocl_axil_reg_file: vector table of write/read-back pairs plus
// hand sequences for read stall, write/read collision, mid-transaction reset and access counters.
module tb_ocl_axil_reg_file;
    logic        clk_main_a0 = 1'b0;
    logic        rst_main_n;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp, s_rresp;
    logic [15:0] vled_src;

    ocl_axil_reg_file #(.DEPTH(1024), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .clk_main_a0(clk_main_a0), .rst_main_n(rst_main_n),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .vled_src(vled_src)
    );

    always #5 clk_main_a0 = ~clk_main_a0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  mode;     // 0: AW+W together, 1: AW first, 2: W first (3 cycles ahead)
        logic [1:0]  bresp;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic [15:0] vled;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  rresp;
    } rexp_t;

    logic [1:0]  exp_b_q[$];
    rexp_t       exp_r_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_vled = 16'h0000;
    vec_t        vecs [12];

`ifdef OCL_RF_ACCESS_CNT_EN
    localparam logic [31:0] OOR_ADDR = 32'h0000_1008;
`else
    localparam logic [31:0] OOR_ADDR = 32'h0000_1000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        int n = 0;
        s_awvalid = 1'b1;
        s_awaddr  = addr;
        @(negedge clk_main_a0);
        while (!s_awready && n < 20) begin @(negedge clk_main_a0); n++; end
        check("aw_handshake", 32'(s_awready), 32'd1);
        tick();
        s_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_wvalid = 1'b1;
        s_wdata  = data;
        s_wstrb  = strb;
        @(negedge clk_main_a0);
        while (!s_wready && n < 20) begin @(negedge clk_main_a0); n++; end
        check("w_handshake", 32'(s_wready), 32'd1);
        tick();
        s_wvalid = 1'b0;
    endtask

    task automatic send_both(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        s_awvalid = 1'b1; s_awaddr = addr;
        s_wvalid  = 1'b1; s_wdata  = data; s_wstrb = strb;
        @(negedge clk_main_a0);
        while (!(s_awready && s_wready) && n < 20) begin @(negedge clk_main_a0); n++; end
        check("aw_w_handshake", 32'(s_awready & s_wready), 32'd1);
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
    endtask

    task automatic pop_b(input string name);
        logic [1:0] e;
        if (exp_b_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: B scoreboard empty", name);
        end else begin
            e = exp_b_q.pop_front();
            check(name, 32'(s_bresp), 32'(e));
        end
    endtask

    task automatic pop_r(input string name);
        rexp_t e;
        if (exp_r_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: R scoreboard empty", name);
        end else begin
            e = exp_r_q.pop_front();
            check({name, "_rdata"}, s_rdata, e.rdata);
            check({name, "_rresp"}, 32'(s_rresp), 32'(e.rresp));
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] mode, input logic [1:0] bresp, input logic [15:0] vled);
        exp_b_q.push_back(bresp);
        case (mode)
            2'd1:    begin send_aw(addr); tick(); send_w(data, strb); end
            2'd2:    begin send_w(data, strb); tick(); tick(); send_aw(addr); end
            default: send_both(addr, data, strb);
        endcase
        @(negedge clk_main_a0);
        check("bvalid_after_commit", 32'(s_bvalid), 32'd1);
        check("vled_src", 32'(vled_src), 32'(vled));
        pop_b("bresp");
        tick();
    endtask

    task automatic wait_rvalid();
        int lat = 0;
        do begin
            @(negedge clk_main_a0);
            lat++;
        end while (!s_rvalid && lat < 10);
        check("r_latency", 32'(lat), 32'd2);
    endtask

    task automatic issue_ar(input logic [31:0] addr);
        int n = 0;
        s_arvalid = 1'b1;
        s_araddr  = addr;
        @(negedge clk_main_a0);
        while (!s_arready && n < 20) begin @(negedge clk_main_a0); n++; end
        check("ar_handshake", 32'(s_arready), 32'd1);
        tick();
        s_arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] rresp);
        exp_r_q.push_back('{rdata, rresp});
        issue_ar(addr);
        wait_rvalid();
        pop_r("read");
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 2'd0, 2'b00, 32'h1234_5678, 2'b00, 16'h0000};
        vecs[1]  = '{32'h0000_0010, 32'hAABB_CCDD, 4'h5, 2'd2, 2'b00, 32'h12BB_56DD, 2'b00, 16'h0000};
        vecs[2]  = '{32'h0000_0000, 32'h0000_BEEF, 4'hF, 2'd0, 2'b00, 32'h0000_BEEF, 2'b00, 16'hBEEF};
        vecs[3]  = '{32'h0000_0000, 32'h1234_5678, 4'hC, 2'd1, 2'b00, 32'h1234_BEEF, 2'b00, 16'hBEEF};
        vecs[4]  = '{OOR_ADDR,      32'h1111_1111, 4'hF, 2'd0, 2'b10, 32'hDEAD_BEEF, 2'b10, 16'hBEEF};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 4'h0, 2'd0, 2'b00, 32'h1234_BEEF, 2'b00, 16'hBEEF};
        vecs[6]  = '{32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 2'd1, 2'b00, 32'hCAFE_F00D, 2'b00, 16'hBEEF};
        vecs[7]  = '{32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 2'd2, 2'b00, 32'hA5A5_A5A5, 2'b00, 16'hBEEF};
        vecs[8]  = '{32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 2'd0, 2'b00, 32'hA5A5_A5A5, 2'b00, 16'hBEEF};
        vecs[9]  = '{32'h0000_0013, 32'h0000_0000, 4'h8, 2'd2, 2'b00, 32'h00BB_56DD, 2'b00, 16'hBEEF};
        vecs[10] = '{32'hFFFF_0000, 32'h9999_9999, 4'hF, 2'd1, 2'b10, 32'hDEAD_BEEF, 2'b10, 16'hBEEF};
        vecs[11] = '{32'h0000_0001, 32'h0000_CA00, 4'h2, 2'd0, 2'b00, 32'h1234_CAEF, 2'b00, 16'hCAEF};

        rst_main_n = 1'b0;
        s_awvalid = 1'b0; s_awaddr = 32'h0; s_wvalid = 1'b0; s_wdata = 32'h0; s_wstrb = 4'h0;
        s_bready = 1'b1; s_arvalid = 1'b0; s_araddr = 32'h0; s_rready = 1'b1;

        repeat (3) tick();
        @(negedge clk_main_a0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_rdata", s_rdata, 32'h0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_vled", 32'(vled_src), 32'h0);
        rst_main_n = 1'b1;
        repeat (4) tick();
        check("idle_awready", 32'(s_awready), 32'd1);
        check("idle_wready", 32'(s_wready), 32'd1);
        check("idle_arready", 32'(s_arready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].mode, vecs[i].bresp, vecs[i].vled);
            do_read(vecs[i].addr, vecs[i].rdata, vecs[i].rresp);
        end
        exp_vled = 16'hCAEF;

        // Read held with rready low while a write to the same word completes.
        s_rready = 1'b0;
        exp_r_q.push_back('{32'h00BB_56DD, 2'b00});
        issue_ar(32'h0000_0010);
        wait_rvalid();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_main_a0);
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'h00BB_56DD);
            check("stall_arready", 32'(s_arready), 32'd0);
        end
        tick();
        do_write(32'h0000_0010, 32'h0102_0304, 4'hF, 2'd0, 2'b00, exp_vled);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_main_a0);
            check("stall_rvalid", 32'(s_rvalid), 32'd1);
            check("stall_rdata", s_rdata, 32'h00BB_56DD);
            check("stall_arready", 32'(s_arready), 32'd0);
        end
        pop_r("stall");
        s_rready = 1'b1;
        tick();
        @(negedge clk_main_a0);
        check("stall_released_rvalid", 32'(s_rvalid), 32'd0);
        tick();
        do_read(32'h0000_0010, 32'h0102_0304, 2'b00);

        // Commit lands in the R_LOOK cycle of a read of the same word.
        issue_ar(32'h0000_0010);
        exp_r_q.push_back('{32'h0102_C0D0, 2'b00});
        exp_b_q.push_back(2'b00);
        s_awvalid = 1'b1; s_awaddr = 32'h0000_0010;
        s_wvalid  = 1'b1; s_wdata  = 32'hA0B0_C0D0; s_wstrb = 4'h3;
        @(negedge clk_main_a0);
        check("coll_aw_w_ready", 32'(s_awready & s_wready), 32'd1);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        @(negedge clk_main_a0);
        check("coll_rvalid", 32'(s_rvalid), 32'd1);
        check("coll_bvalid", 32'(s_bvalid), 32'd1);
        pop_r("collision");
        pop_b("coll_bresp");
        tick();
        do_read(32'h0000_0010, 32'h0102_C0D0, 2'b00);

        // Reset while the write FSM holds an address waiting for data.
        send_aw(32'h0000_0040);
        @(negedge clk_main_a0);
        check("gota_awready", 32'(s_awready), 32'd0);
        rst_main_n = 1'b0;
        #1;
        check("midrst_bvalid", 32'(s_bvalid), 32'd0);
        check("midrst_rvalid", 32'(s_rvalid), 32'd0);
        check("midrst_wready", 32'(s_wready), 32'd0);
        tick(); tick();
        @(negedge clk_main_a0);
        rst_main_n = 1'b1;
        repeat (4) tick();
        @(negedge clk_main_a0);
        check("postrst_awready", 32'(s_awready), 32'd1);
        check("postrst_wready", 32'(s_wready), 32'd1);
        check("postrst_bvalid", 32'(s_bvalid), 32'd0);
        check("postrst_vled", 32'(vled_src), 32'h0);
        check("postrst_rdata", s_rdata, 32'h0);
        exp_vled = 16'h0000;
        tick();

`ifdef OCL_RF_ACCESS_CNT_EN
        do_read(32'h0000_1000, 32'd0, 2'b00);
        do_write(32'h0000_0030, 32'h0000_0001, 4'hF, 2'd0, 2'b00, exp_vled);
        do_write(32'h0000_0034, 32'h0000_0002, 4'hF, 2'd1, 2'b00, exp_vled);
        do_write(32'h0000_0038, 32'h0000_0003, 4'hF, 2'd2, 2'b00, exp_vled);
        do_read(32'h0000_0030, 32'h0000_0001, 2'b00);
        do_read(32'h0000_1004, 32'd2, 2'b00);
        do_read(32'h0000_1000, 32'd3, 2'b00);
        do_write(32'h0000_1004, 32'h0000_0000, 4'hF, 2'd0, 2'b10, exp_vled);
        do_read(32'h0000_1000, 32'd4, 2'b00);
        do_read(32'h0000_1004, 32'd5, 2'b00);
`else
        do_write(32'h0000_1004, 32'h0000_0000, 4'hF, 2'd0, 2'b10, exp_vled);
        do_read(32'h0000_1004, 32'hDEAD_BEEF, 2'b10);
        do_read(32'h0000_1000, 32'hDEAD_BEEF, 2'b10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ocl_axil_reg_file.md
Name: ocl_axil_reg_file

Overview:
AXI4-Lite slave register file that consumes the master side of the OCL AXI-L register slice (AppPF BAR0 path).
- Provides a DEPTH-word, byte-strobed, dual-port register array.
- Write and read channels are handled independently, with correct AW/W decoupling and error responses for out-of-range accesses.
- Word 0 [15:0] is exported as the virtual-LED source.

Parameters:
DEPTH, 1024, number of 32-bit words; power of two, 16..4096
ERR_RDATA, 32'hDEAD_BEEF, rdata returned on SLVERR reads

Ports:
clk_main_a0  in  1  clock
rst_main_n  in  1  reset
s_awvalid  in  1  write address valid
s_awaddr  in  32  write byte address
s_awready  out  1  write address ready
s_wvalid  in  1  write data valid
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_wready  out  1  write data ready
s_bvalid  out  1  write response valid
s_bresp  out  2  write response; 2'b00 OKAY, 2'b10 SLVERR
s_bready  in  1  write response ready
s_arvalid  in  1  read address valid
s_araddr  in  32  read byte address
s_arready  out  1  read address ready
s_rvalid  out  1  read data valid
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rready  in  1  read data ready
vled_src  out  16  registered copy of word 0 [15:0]

Behaviour:
- Reset: rst_main_n, asynchronous, active-low. Clock: clk_main_a0. Deassertion is synchronized internally with a 2-flop synchronizer.
- Values in reset: write FSM W_IDLE, read FSM R_IDLE, bvalid=0, bresp=0, rvalid=0, rdata=0, rresp=0, vled_src=0. Array contents are not reset (undefined).
- Addressing: word index = addr[log2(DEPTH)+1:2]. addr[1:0] is ignored. In range when addr < DEPTH*4; otherwise SLVERR.
- Write FSM states:
  - W_IDLE: awready=1, wready=1.
  - W_GOTA: AW held; wready=1, awready=0.
  - W_GOTD: W held; awready=1, wready=0.
  - W_RESP: awready=0, wready=0.
- Write FSM transitions:
  - W_IDLE: AW and W in the same cycle -> commit, go to W_RESP. AW only -> W_GOTA. W only -> W_GOTD.
  - W_GOTA / W_GOTD: on the missing handshake -> commit, go to W_RESP.
  - W_RESP: bvalid=1; on bready -> W_IDLE.
- Write commit:
  - The array write occurs in the commit cycle, per byte where wstrb[i]=1.
  - wstrb=0 is legal: no bytes change, response is OKAY.
  - Out-of-range: no write, bresp=SLVERR.
  - bvalid rises the cycle after commit.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake, latch address -> R_LOOK.
  - R_LOOK: one array-read cycle -> R_RESP.
  - R_RESP: rvalid=1, rdata/rresp held stable until rready -> R_IDLE.
  - Latency from AR handshake to rvalid is 2 cycles. Max one outstanding read and one outstanding write.
- Out-of-range read: rdata=ERR_RDATA, rresp=SLVERR.
- Collision: a write commit and R_LOOK on the same word in the same cycle return the NEW (write-first, byte-merged) data.
- vled_src: updated the cycle after any commit touching word 0 bytes 0/1.
- Reset mid-transaction: all handshakes are dropped immediately; no response is issued for the aborted transaction.

Optional Feature:
OCL_RF_ACCESS_CNT_EN
- Defined: two read-only 32-bit counters.
  - WR_CNT at byte address DEPTH*4: counts B handshakes.
  - RD_CNT at DEPTH*4+4: counts R handshakes.
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - A read returns the value sampled in R_LOOK.
  - Writes to either address: ignored, bresp=SLVERR.
- Undefined: these addresses are ordinary out-of-range (SLVERR/ERR_RDATA) and no counter logic exists.

Test Plan:
1. AW 0x10 and W 0x12345678/strb F in the same cycle, then AR 0x10 -> bresp=0; rdata=0x12345678 two cycles after AR handshake.
2. W (0xAABBCCDD, strb 4'b0101) three cycles before AW 0x10, on top of test 1 data -> commit on AW; read 0x10 returns 0x12BB56DD.
3. Write 0x0000BEEF to address 0x0 -> vled_src=16'hBEEF one cycle after commit; write strb 4'b1100 -> vled_src unchanged.
4. Write 0x1000 and read 0x1000 (DEPTH=1024) -> bresp=2'b10; rresp=2'b10, rdata=0xDEADBEEF; array unchanged.
5. Hold rready=0 for 5 cycles after rvalid -> rvalid/rdata stable and arready=0 throughout; a concurrent write to the same word completes, and the held rdata is not altered.
6. With OCL_RF_ACCESS_CNT_EN: 3 writes, 2 reads, then read 0x1000 -> 3; read 0x1004 -> 2. Assert rst_main_n low mid-W_GOTA -> all valids low, counters 0.
